mix_columns_seq: RTL and testbench



---
 rtl/mix_columns_seq.sv | 155 +++++++++++++++
 tb/tb_mix_columns_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Build option: define MIXCOL_INV_EN to add the in_inv port and the InvMixColumns matrix.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef MIXCOL_INV_EN
  input  logic         in_inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e       state_q;
  logic [1:0]   cnt_q;
  logic [127:0] st_q;
  logic [127:0] st_d;
  logic [127:0] out_q;
  logic         vld_q;
`ifdef MIXCOL_INV_EN
  logic         inv_q;
`endif

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a, b, cc, d;
    {a, b, cc, d} = c;
    return {xt(a) ^ xt(b) ^ b ^ cc ^ d,
            a ^ xt(b) ^ xt(cc) ^ cc ^ d,
            a ^ b ^ xt(cc) ^ xt(d) ^ d,
            xt(a) ^ a ^ b ^ cc ^ xt(d)};
  endfunction

`ifdef MIXCOL_INV_EN
  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [7:0]  v [4];
    logic [7:0]  m9 [4];
    logic [7:0]  m11 [4];
    logic [7:0]  m13 [4];
    logic [7:0]  m14 [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v[i]   = c[31-8*i -: 8];
      x2     = xt(v[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ v[i];
      m11[i] = x8 ^ x2 ^ v[i];
      m13[i] = x8 ^ x4 ^ v[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    // Row r uses the same coefficient set rotated right by r.
    for (int rr = 0; rr < 4; rr++) begin
      r[31-8*rr -: 8] = m14[rr] ^ m11[(rr+1)%4] ^ m13[(rr+2)%4] ^ m9[(rr+3)%4];
    end
    return r;
  endfunction
`endif

  always_comb begin
    logic [1:0]  idx;
    logic [31:0] col;
    st_d = st_q;
    idx  = '0;
    col  = '0;
    for (int u = 0; u < COLS_PER_CYCLE; u++) begin
      idx = cnt_q + 2'(u);
      col = st_q[127-32*int'(idx) -: 32];
`ifdef MIXCOL_INV_EN
      st_d[127-32*int'(idx) -: 32] = inv_q ? mix_inv(col) : mix_fwd(col);
`else
      st_d[127-32*int'(idx) -: 32] = mix_fwd(col);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            st_q    <= in_data;
            cnt_q   <= '0;
            state_q <= S_BUSY;
`ifdef MIXCOL_INV_EN
            inv_q   <= in_inv;
`endif
          end
        end
        S_BUSY: begin
          st_q  <= st_d;
          cnt_q <= cnt_q + CNT_STEP;
          if (cnt_q == CNT_LAST) begin
            out_q   <= st_d;
            vld_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            vld_q <= 1'b0;
            if (in_valid) begin
              st_q    <= in_data;
              cnt_q   <= '0;
              state_q <= S_BUSY;
`ifdef MIXCOL_INV_EN
              inv_q   <= in_inv;
`endif
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is the only combinational input-to-output path (through out_ready in DONE).
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = vld_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq with a GF(2^8) matrix model and a scoreboard on the output side.
module tb_mix_columns_seq;

  localparam int CPC = 1;
  localparam int LAT = 4 / CPC + 1;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COL_IN   = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] COL_OUT  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];
  int           out_times [$];
  logic [127:0] prev_data;
  logic         prev_hold = 1'b0;

  mix_columns_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MIXCOL_INV_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a, b;
    logic       hi;
    p = 8'h00; a = x; b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   b [4];
    logic [7:0]   o;
    logic [127:0] r;
    r = '0;
    if (inv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) b[k] = s[127-32*c-8*k -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int k = 0; k < 4; k++) o ^= gmul(coef[(k - rr + 4) % 4], b[k]);
        r[127-32*c-8*rr -: 8] = o;
      end
    end
    return r;
  endfunction

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: outputs checked on every retiring handshake, holds checked while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk128("hold_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got %h expected no output", out_data);
        end else begin
          chk128("scoreboard", out_data, exp_q.pop_front());
        end
        out_times.push_back(cyc);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_inv));
    end
  end

  task automatic send(input logic [127:0] d, input logic inv);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_inv = inv;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) return;
    end
    checks++; errors++;
    $display("FAIL valid_timeout: got out_valid=0 expected 1 within 40 cycles");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [127:0] b2b [3];
    b2b[0] = FIPS_IN;
    b2b[1] = COL_IN;
    b2b[2] = 128'h00112233445566778899aabbccddeeff;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_inv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chkint("reset_out_valid", out_valid, 0);
    chkint("reset_in_ready", in_ready, 1);
    chk128("reset_out_data", out_data, '0);

    chk128("model_fips", model(FIPS_IN, 1'b0), FIPS_OUT);
    chk128("model_cols", model(COL_IN, 1'b0), COL_OUT);
`ifdef MIXCOL_INV_EN
    chk128("model_inv", model(FIPS_OUT, 1'b1), FIPS_IN);
`endif

    // Reset while BUSY discards the operation.
    out_ready = 1'b1;
    send(128'h0123456789abcdef0011223344556677, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chkint("midrst_out_valid", out_valid, 0);
    chkint("midrst_in_ready", in_ready, 1);
    chk128("midrst_out_data", out_data, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chkint("midrst_no_output", out_valid, 0);
    end

    // FIPS-197 vector and latency.
    send(FIPS_IN, 1'b0);
    wait_valid(n);
    chkint("latency", n, LAT);
    chk128("fips_out", out_data, FIPS_OUT);

    send(COL_IN, 1'b0);
    wait_valid(n);
    chk128("cols_out", out_data, COL_OUT);

    // Backpressure in DONE with a pending input.
    @(posedge clk); #1 out_ready = 1'b0;
    send(FIPS_IN, 1'b0);
    wait_valid(n);
    in_valid = 1'b1; in_data = COL_IN; in_inv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chkint("bp_in_ready", in_ready, 0);
      chkint("bp_out_valid", out_valid, 1);
      chk128("bp_out_data", out_data, FIPS_OUT);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chkint("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chkint("bp_busy_out_valid", out_valid, 0);
    chkint("bp_busy_in_ready", in_ready, 0);
    wait_valid(n);
    chk128("bp_second_out", out_data, COL_OUT);

    // Back-to-back stream with both sides always ready.
    @(posedge clk); #1;
    out_times.delete();
    in_valid = 1'b1; in_data = b2b[0]; in_inv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit ok;
      ok = 1'b0;
      for (int j = 0; j < 50; j++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL b2b_accept: got in_ready=0 expected 1 for item %0d", i);
      end
      @(posedge clk); #1;
      if (i < 2) in_data = b2b[i+1];
      else       in_valid = 1'b0;
    end
    for (int i = 0; i < 40 && out_times.size() < 3; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chkint("b2b_count", out_times.size(), 3);
    if (out_times.size() == 3) begin
      chkint("b2b_period_1", out_times[1] - out_times[0], LAT);
      chkint("b2b_period_2", out_times[2] - out_times[1], LAT);
    end

`ifdef MIXCOL_INV_EN
    send(FIPS_OUT, 1'b1);
    wait_valid(n);
    chkint("inv_latency", n, LAT);
    chk128("inv_out", out_data, FIPS_IN);
    send(FIPS_IN, 1'b0);
    wait_valid(n);
    chk128("fwd_after_inv", out_data, FIPS_OUT);
`endif

    @(posedge clk);
    @(negedge clk);
    chkint("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
